// File: rtl/dct_pkg.sv
// Shared types and constants for the DCT coefficient collector.
package dct_pkg;

  localparam int DATA_W    = 22;
  localparam int N         = 4;
  localparam int BLK_COEFS = 16;

  localparam logic [3:0] LAST_IDX = 4'(BLK_COEFS - 1);

  typedef logic [DATA_W-1:0] coef_t;
  typedef coef_t [N-1:0]     col_t;

endpackage

// File: rtl/dct_coef_bank.sv
// One 4x4 coefficient bank: whole-column write port, combinational element read.
module dct_coef_bank
  import dct_pkg::*;
(
  input  logic                clk,
  input  logic                we,
  input  logic [1:0]          wcol,
  input  logic [N*DATA_W-1:0] wdata,
  input  logic [1:0]          rrow,
  input  logic [1:0]          rcol,
  output logic [DATA_W-1:0]   rdata
);

  coef_t mem_q [N][N];
  col_t  wcol_data;

  assign wcol_data = wdata;

  // Storage only; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int r = 0; r < N; r++) begin
        mem_q[r][wcol] <= wcol_data[r];
      end
    end
  end

  assign rdata = mem_q[rrow][rcol];

endmodule

// File: rtl/dct_coef_collector.sv
// Reassembles 4x4 blocks from a column stream into ping-pong banks and drains them
// row-major over valid/ready. Optional counters behind DCT_COLLECT_BLKCNT_EN.
module dct_coef_collector
  import dct_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] col_in0,
  input  logic [DATA_W-1:0] col_in1,
  input  logic [DATA_W-1:0] col_in2,
  input  logic [DATA_W-1:0] col_in3,
  output logic              coef_valid,
  input  logic              coef_ready,
  output logic [DATA_W-1:0] coef_data,
  output logic [1:0]        coef_row,
  output logic [1:0]        coef_col,
  output logic              coef_last,
`ifdef DCT_COLLECT_BLKCNT_EN
  output logic [15:0]       blk_count,
  output logic [7:0]        drop_count,
`endif
  output logic              overflow
);

  logic       wr_bank_q, wr_bank_d;
  logic       rd_bank_q, rd_bank_d;
  logic [1:0] wr_col_q, wr_col_d;
  logic [1:0] full_q, full_d;
  logic       drop_q, drop_d;
  logic [3:0] rd_idx_q, rd_idx_d;
  logic       overflow_q, overflow_d;

  logic       xfer, blk_release, drop_now, wr_en, drop_evt;
  logic [1:0] full_rel;
  logic [N*DATA_W-1:0] wr_data;
  logic [DATA_W-1:0]   rdata0, rdata1;

  assign wr_data = {col_in3, col_in2, col_in1, col_in0};

  always_comb begin
    xfer        = full_q[rd_bank_q] && coef_ready;
    blk_release = xfer && (rd_idx_q == LAST_IDX);

    // A bank freed by this cycle's final handshake is already writable.
    full_rel = full_q;
    if (blk_release) full_rel[rd_bank_q] = 1'b0;

    drop_now = (wr_col_q == 2'd0) ? full_rel[wr_bank_q] : drop_q;
    wr_en    = valid_in && !drop_now;
    drop_evt = valid_in && (wr_col_q == 2'd0) && drop_now;

    full_d     = full_rel;
    wr_bank_d  = wr_bank_q;
    wr_col_d   = wr_col_q;
    drop_d     = drop_q;
    overflow_d = overflow_q;
    rd_bank_d  = rd_bank_q;
    rd_idx_d   = rd_idx_q;

    if (valid_in) begin
      wr_col_d = wr_col_q + 2'd1;
      if (drop_evt) begin
        drop_d     = 1'b1;
        overflow_d = 1'b1;
      end
      if (wr_col_q == 2'd3) begin
        drop_d = 1'b0;
        if (!drop_now) begin
          full_d[wr_bank_q] = 1'b1;
          wr_bank_d         = ~wr_bank_q;
        end
      end
    end

    if (xfer) begin
      rd_idx_d = rd_idx_q + 4'd1;
      if (blk_release) rd_bank_d = ~rd_bank_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_bank_q  <= 1'b0;
      rd_bank_q  <= 1'b0;
      wr_col_q   <= 2'd0;
      full_q     <= 2'b00;
      drop_q     <= 1'b0;
      rd_idx_q   <= 4'd0;
      overflow_q <= 1'b0;
    end else begin
      wr_bank_q  <= wr_bank_d;
      rd_bank_q  <= rd_bank_d;
      wr_col_q   <= wr_col_d;
      full_q     <= full_d;
      drop_q     <= drop_d;
      rd_idx_q   <= rd_idx_d;
      overflow_q <= overflow_d;
    end
  end

`ifdef DCT_COLLECT_BLKCNT_EN
  logic [15:0] blk_cnt_q;
  logic [7:0]  drop_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blk_cnt_q  <= 16'd0;
      drop_cnt_q <= 8'd0;
    end else begin
      if (blk_release) blk_cnt_q <= blk_cnt_q + 16'd1;
      if (drop_evt && (drop_cnt_q != 8'hFF)) drop_cnt_q <= drop_cnt_q + 8'd1;
    end
  end

  assign blk_count  = blk_cnt_q;
  assign drop_count = drop_cnt_q;
`endif

  dct_coef_bank u_bank0 (
    .clk   (clk),
    .we    (wr_en && !wr_bank_q),
    .wcol  (wr_col_q),
    .wdata (wr_data),
    .rrow  (rd_idx_q[3:2]),
    .rcol  (rd_idx_q[1:0]),
    .rdata (rdata0)
  );

  dct_coef_bank u_bank1 (
    .clk   (clk),
    .we    (wr_en && wr_bank_q),
    .wcol  (wr_col_q),
    .wdata (wr_data),
    .rrow  (rd_idx_q[3:2]),
    .rcol  (rd_idx_q[1:0]),
    .rdata (rdata1)
  );

  // Data is gated so unreset bank contents never reach the port while idle.
  assign coef_valid = full_q[rd_bank_q];
  assign coef_data  = coef_valid ? (rd_bank_q ? rdata1 : rdata0) : '0;
  assign coef_row   = rd_idx_q[3:2];
  assign coef_col   = rd_idx_q[1:0];
  assign coef_last  = coef_valid && (rd_idx_q == LAST_IDX);
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_dct_coef_collector.sv
// Scoreboard bench for dct_coef_collector: directed blocks, back-pressure, overrun, release bypass.
module tb_dct_coef_collector;
  import dct_pkg::*;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              valid_in = 1'b0;
  logic [DATA_W-1:0] col_in0 = '0, col_in1 = '0, col_in2 = '0, col_in3 = '0;
  logic              coef_ready = 1'b0;
  logic              coef_valid, coef_last, overflow;
  logic [DATA_W-1:0] coef_data;
  logic [1:0]        coef_row, coef_col;
`ifdef DCT_COLLECT_BLKCNT_EN
  logic [15:0]       blk_count;
  logic [7:0]        drop_count;
`endif

  dct_coef_collector dut (
    .clk        (clk),
    .rst        (rst),
    .valid_in   (valid_in),
    .col_in0    (col_in0),
    .col_in1    (col_in1),
    .col_in2    (col_in2),
    .col_in3    (col_in3),
    .coef_valid (coef_valid),
    .coef_ready (coef_ready),
    .coef_data  (coef_data),
    .coef_row   (coef_row),
    .coef_col   (coef_col),
    .coef_last  (coef_last),
`ifdef DCT_COLLECT_BLKCNT_EN
    .blk_count  (blk_count),
    .drop_count (drop_count),
`endif
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DATA_W-1:0] d;
    logic [1:0]        r;
    logic [1:0]        c;
    logic              l;
  } exp_t;

  exp_t q[$];
  exp_t e_mon;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: pops on every handshake, and checks outputs stayed put across a stall.
  logic              pv = 1'b0, pr = 1'b0, pl = 1'b0;
  logic [DATA_W-1:0] pd = '0;
  logic [1:0]        prw = '0, pcl = '0;

  always @(negedge clk) begin
    if (!rst) begin
      if (pv && !pr) begin
        chk("hold_valid", 32'(coef_valid), 32'd1);
        chk("hold_data",  32'(coef_data),  32'(pd));
        chk("hold_row",   32'(coef_row),   32'(prw));
        chk("hold_col",   32'(coef_col),   32'(pcl));
        chk("hold_last",  32'(coef_last),  32'(pl));
      end
      if (coef_valid && coef_ready) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_coef actual=%0d required=none", coef_data);
        end else begin
          e_mon = q.pop_front();
          chk("coef_data", 32'(coef_data), 32'(e_mon.d));
          chk("coef_row",  32'(coef_row),  32'(e_mon.r));
          chk("coef_col",  32'(coef_col),  32'(e_mon.c));
          chk("coef_last", 32'(coef_last), 32'(e_mon.l));
        end
      end
      pv  = coef_valid;
      pr  = coef_ready;
      pd  = coef_data;
      prw = coef_row;
      pcl = coef_col;
      pl  = coef_last;
    end else begin
      pv = 1'b0;
    end
  end

  task automatic push_block(input int base);
    exp_t e;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        e.d = DATA_W'(base + 16 * r + c);
        e.r = 2'(r);
        e.c = 2'(c);
        e.l = (r == 3) && (c == 3);
        q.push_back(e);
      end
    end
  endtask

  // Back-to-back blocks; block b uses base+100*b and is expected only if keep[b] is set.
  task automatic send_blocks(input int base, input int n, input int keep);
    int bb;
    for (int b = 0; b < n; b++) begin
      bb = base + 100 * b;
      if (keep[b]) push_block(bb);
      for (int c = 0; c < 4; c++) begin
        valid_in = 1'b1;
        col_in0  = DATA_W'(bb + c);
        col_in1  = DATA_W'(bb + 16 + c);
        col_in2  = DATA_W'(bb + 32 + c);
        col_in3  = DATA_W'(bb + 48 + c);
        @(posedge clk); #1;
      end
    end
    valid_in = 1'b0;
  endtask

  task automatic wait_drain(input int budget, input string name);
    int n = 0;
    while (q.size() != 0 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL %s actual=%0d pending required=0 pending", name, q.size());
      q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Asynchronous reset asserted between clock edges.
    #12 rst = 1'b1;
    #1;
    chk("rst_valid",    32'(coef_valid), 32'd0);
    chk("rst_last",     32'(coef_last),  32'd0);
    chk("rst_overflow", 32'(overflow),   32'd0);
    chk("rst_data",     32'(coef_data),  32'd0);
    chk("rst_row",      32'(coef_row),   32'd0);
    chk("rst_col",      32'(coef_col),   32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    chk("idle_valid", 32'(coef_valid), 32'd0);

    // Single block, ready high throughout.
    coef_ready = 1'b1;
    send_blocks(0, 1, 1);
    chk("latency_valid", 32'(coef_valid), 32'd1);
    chk("first_data",    32'(coef_data),  32'd0);
    repeat (16) begin @(posedge clk); #1; end
    chk("drain_16_cycles", 32'(q.size()),  32'd0);
    chk("valid_after",     32'(coef_valid), 32'd0);

    // Back-pressure with ready pattern 1,0,0,1.
    fork
      send_blocks(1000, 1, 1);
      begin
        for (int i = 0; i < 80; i++) begin
          coef_ready = (i % 4 == 0) || (i % 4 == 3);
          @(posedge clk); #1;
        end
      end
    join
    wait_drain(40, "bp_drain");

    // Ping-pong: two blocks back to back.
    coef_ready = 1'b1;
    send_blocks(2000, 2, 3);
    wait_drain(60, "pp_drain");
    chk("pp_overflow", 32'(overflow), 32'd0);

    // Overrun: third block must be dropped.
    coef_ready = 1'b0;
    send_blocks(3000, 3, 3);
    chk("ovr_flag",  32'(overflow),   32'd1);
    chk("ovr_valid", 32'(coef_valid), 32'd1);
    repeat (4) begin @(posedge clk); #1; end
    coef_ready = 1'b1;
    wait_drain(60, "ovr_drain");
    repeat (4) begin @(posedge clk); #1; end
    chk("ovr_sticky", 32'(overflow),   32'd1);
    chk("ovr_empty",  32'(coef_valid), 32'd0);

    // Reset again, then land beat 0 on the final handshake of a full bank.
    #3 rst = 1'b1;
    #1;
    chk("rst2_overflow", 32'(overflow), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    coef_ready = 1'b0;
    send_blocks(4000, 2, 3);
    repeat (2) begin @(posedge clk); #1; end
    coef_ready = 1'b1;
    repeat (15) begin @(posedge clk); #1; end
    send_blocks(5000, 1, 1);
    wait_drain(80, "byp_drain");
    chk("byp_overflow", 32'(overflow), 32'd0);
`ifdef DCT_COLLECT_BLKCNT_EN
    chk("blk_count",  32'(blk_count),  32'd3);
    chk("drop_count", 32'(drop_count), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
